// File: rtl/top_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// MEM control vector : bit2 Branch, bit1 MemRead, bit0 MemWrite
// WB control vector  : bit1 RegWrite, bit0 MemtoReg
// FSM state encoding for the access sequencer.
package top_mem_pkg;

  localparam int unsigned MEM_BRANCH   = 2;
  localparam int unsigned MEM_MEMREAD  = 1;
  localparam int unsigned MEM_MEMWRITE = 0;

  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_MEMTOREG  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/top_mem_data_memory.sv
// Word-addressed data array: asynchronous read, synchronous write.
// Ports:
//   i_clk   - clock, write on posedge
//   i_we    - write enable
//   i_addr  - word index
//   i_wdata - write data
//   o_rdata - combinational read of r_mem[i_addr]
// Contents are not reset.
module data_memory #(
  parameter int unsigned WORDS = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/top_mem.sv
// MEM pipeline stage with a variable-latency data memory and MEM/WB register.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   result_in            - ALU result, byte address for loads/stores
//   zero_in              - ALU zero flag
//   read_d2_in           - store data
//   write_register_in    - destination register
//   MEM_in               - {Branch, MemRead, MemWrite}
//   WB_in                - {RegWrite, MemtoReg}
//   read_data_out        - registered load data
//   alu_result_out       - registered ALU result
//   write_register_out   - registered destination register
//   WB_out               - registered WB control (0 = bubble)
//   PCSrc                - Branch & zero_in, combinational
//   stall                - memory op still in progress, combinational
//   align_err            - one-cycle pulse after a misaligned access
module top_mem
  import top_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_in,
  input  logic        zero_in,
  input  logic [31:0] read_d2_in,
  input  logic [4:0]  write_register_in,
  input  logic [2:0]  MEM_in,
  input  logic [1:0]  WB_in,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_register_out,
  output logic [1:0]  WB_out,
  output logic        PCSrc,
  output logic        stall,
  output logic        align_err
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT = 4'(MEM_LATENCY);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [4:0]  r_write_register;
  logic [1:0]  r_wb;
  logic        r_align_err;

  logic          w_memread;
  logic          w_memwrite;
  logic          w_memop;
  logic          w_aligned;
  logic          w_done;
  logic          w_stall;
  logic          w_we;
  logic          w_load;
  logic [AW-1:0] w_index;
  logic [31:0]   w_rdata;

  assign w_memread  = MEM_in[MEM_MEMREAD];
  assign w_memwrite = MEM_in[MEM_MEMWRITE];
  assign w_memop    = w_memread | w_memwrite;
  assign w_aligned  = (result_in[1:0] == 2'b00);
  assign w_done     = (r_cnt == LAT);
  assign w_stall    = w_memop & w_aligned & ~w_done;
  // Read+write together behaves as a store only.
  assign w_we       = w_memwrite & w_aligned & w_done & rst;
  assign w_load     = w_memread & ~w_memwrite & w_aligned & w_done;
  assign w_index    = result_in[AW+1:2];

  data_memory #(
    .WORDS (MEM_WORDS)
  ) u_dmem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_index),
    .i_wdata (read_d2_in),
    .o_rdata (w_rdata)
  );

  // Access sequencer. IDLE implies cnt == 0, so the first stalling cycle
  // loads 1 directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_stall) begin
            r_state <= ST_BUSY;
            r_cnt   <= 4'd1;
          end else begin
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (w_stall) begin
            r_cnt   <= r_cnt + 4'd1;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data      <= '0;
      r_alu_result     <= '0;
      r_write_register <= '0;
      r_wb             <= '0;
      r_align_err      <= 1'b0;
    end else begin
      r_align_err <= w_memop & ~w_aligned;
      if (w_stall) begin
        r_wb <= '0;
      end else begin
        r_alu_result     <= result_in;
        r_write_register <= write_register_in;
        r_wb             <= (w_memop & ~w_aligned) ? 2'b00 : WB_in;
        if (w_load) r_read_data <= w_rdata;
      end
    end
  end

  assign read_data_out      = r_read_data;
  assign alu_result_out     = r_alu_result;
  assign write_register_out = r_write_register;
  assign WB_out             = r_wb;
  assign align_err          = r_align_err;
  assign PCSrc              = MEM_in[MEM_BRANCH] & zero_in;
  assign stall              = w_stall;

endmodule
